// File: rtl/sipo_frame_rx_pkg.sv
// Shared definitions for the serial-to-parallel frame receiver:
// FSM state encoding and default frame width.
package sipo_frame_rx_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    // Encoding fixed for compatibility with existing lab-chain tooling; 2'b11 is unused.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_STOP = 2'b10
    } state_t;

endpackage

// File: rtl/sipo_frame_rx_bit_cnt.sv
// Data-bit counter for sipo_frame_rx: synchronous clear and enable,
// terminal count flags the last data bit of a frame.
module sipo_frame_rx_bit_cnt #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: start bit (0), WIDTH data bits LSB-first,
// stop bit (1); good words are presented on p_out with a one-cycle p_valid.
module sipo_frame_rx
    import sipo_frame_rx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             s_en,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    output logic             frame_err,
    output logic             busy
);

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   count;
    logic               tc;
    logic               cnt_clr;
    logic               cnt_en;

    // Counter holds at terminal count so it cannot wrap when WIDTH == 2**CNT_W.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (s_en) begin
            cnt_clr = (state == ST_IDLE) && !s_in;
            cnt_en  = (state == ST_DATA) && !tc;
        end
    end

    sipo_frame_rx_bit_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            p_out     <= '0;
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            p_valid   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_en && !s_in) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (s_en) begin
                        shreg <= {s_in, shreg[WIDTH-1:1]};
                        if (tc) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    // A zero stop bit is only flagged; it never doubles as a start bit.
                    if (s_en) begin
                        if (s_in) begin
                            p_out   <= shreg;
                            p_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_DATA) || (state == ST_STOP);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Scoreboard bench for sipo_frame_rx: frame-level driver pushes expected
// outcomes, a negedge monitor pops them when the DUT pulses.
module tb_sipo_frame_rx;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_in = 1'b0;
    logic         s_en = 1'b1;
    logic [W-1:0] p_out;
    logic         p_valid;
    logic         frame_err;
    logic         busy;

    sipo_frame_rx #(
        .WIDTH (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_in      (s_in),
        .s_en      (s_en),
        .p_out     (p_out),
        .p_valid   (p_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           good;
        logic [W-1:0] word;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] model_pout = '0;
    bit           exp_busy = 1'b0;
    bit           rst_seen = 1'b0;
    int           pulse_cycle = 0;
    int           last_pulse = -100;
    int           cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    always @(posedge clk) begin
        rst_seen = reset;
        cyc++;
    end

    // Monitor: compares outputs produced by the preceding rising edge.
    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(exp_busy));
        check("pulse_exclusive", 32'(p_valid & frame_err), 32'd0);
        if (rst_seen) model_pout = '0;
        if (p_valid || frame_err) begin
            last_pulse = pulse_cycle;
            pulse_cycle = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse at cycle %0d: p_valid=%0b frame_err=%0b, expected none",
                         cyc, p_valid, frame_err);
            end else begin
                cur = exp_q.pop_front();
                check("p_valid", 32'(p_valid), 32'(cur.good));
                check("frame_err", 32'(frame_err), 32'(!cur.good));
                if (cur.good) model_pout = cur.word;
            end
        end
        check("p_out", 32'(p_out), 32'(model_pout));
    end

    task automatic step(input logic en, input logic b);
        s_en = en;
        s_in = b;
        @(posedge clk);
        #1;
    endtask

    // gap idle clocks with s_en=0 and a toggling/random s_in, then one strobed bit.
    task automatic strobe(input logic b, input int gap);
        for (int i = 0; i < gap; i++) step(1'b0, 1'($urandom_range(1)));
        step(1'b1, b);
    endtask

    task automatic send_frame(input logic [W-1:0] w, input bit stop_ok, input int gap);
        exp_t e;
        strobe(1'b0, gap);
        exp_busy = 1'b1;
        for (int i = 0; i < int'(W); i++) strobe(w[i], gap);
        e.good = stop_ok;
        e.word = w;
        exp_q.push_back(e);
        strobe(stop_ok, gap);
        exp_busy = 1'b0;
    endtask

    task automatic abort_frame(input logic [W-1:0] w, input int nbits, input int gap);
        strobe(1'b0, gap);
        exp_busy = 1'b1;
        for (int i = 0; i < nbits; i++) strobe(w[i], gap);
        reset = 1'b1;
        step(1'b1, 1'b0);
        exp_busy = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;
        int           p1;
        int           p2;
        // Reset held for two clocks with a start-like input pattern.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        reset = 1'b0;
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);

        send_frame(8'h4D, 1'b1, 0);
        step(1'b1, 1'b1);
        send_frame(8'h4D, 1'b0, 0);
        step(1'b1, 1'b1);
        send_frame(8'hA5, 1'b1, 0);
        step(1'b0, 1'b1);
        send_frame(8'hC3, 1'b1, 3);
        step(1'b1, 1'b1);

        // Back-to-back frames: pulses must be exactly 10 strobes (clocks) apart.
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        p1 = last_pulse;
        p2 = pulse_cycle;
        check("b2b_spacing", 32'(p2 - p1), 32'd10);

        abort_frame(8'h5A, 4, 0);
        check("p_out_after_reset", 32'(p_out), 32'h00);
        send_frame(8'h3C, 1'b1, 0);
        step(1'b1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            w = W'($urandom);
            if ($urandom_range(9) == 0)
                abort_frame(w, int'($urandom_range(W - 1)), int'($urandom_range(3)));
            else
                send_frame(w, $urandom_range(4) != 0, int'($urandom_range(3)));
            for (int k = 0; k < int'($urandom_range(2)); k++) step(1'b1, 1'b1);
        end

        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sipo_frame_rx.md
Name: sipo_frame_rx

Overview:
- Serial-to-parallel frame receiver that sits directly downstream of a D flip-flop stage.
- It consumes the flip-flop's registered serial output (q) one bit per strobe.
- Frame format: start bit (0), WIDTH data bits LSB-first, stop bit (1). A completed word is presented on a parallel bus with a one-cycle valid pulse.
- It is the first multi-bit consumer of registered serial data in the flip-flop/register lab chain.

Parameters:
- WIDTH, 8, number of data bits per frame (legal range 2..16).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- s_in  input  1  serial data; idle level 1; driven by the upstream D flip-flop q.
- s_en  input  1  bit strobe; s_in is sampled only on edges where s_en=1.
- p_out  output  WIDTH  last correctly framed word; holds its value between frames.
- p_valid  output  1  one-cycle pulse: p_out has just been updated.
- frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0.
- busy  output  1  high while a frame is in progress (state != IDLE).

Behaviour:
- Reset (reset=1 at an edge): state=IDLE, shift register=0, bit counter=0, p_out=0, p_valid=0, frame_err=0, busy=0.
- Reset dominates every other input, including mid-frame; a partial frame is discarded.
- Edges with s_en=0: state, shift register and counter are unchanged; p_valid and frame_err are forced to 0.
- IDLE:
  - s_en=1 and s_in=0 -> DATA, counter=0.
  - s_en=1 and s_in=1 -> stay in IDLE.
- DATA, on each s_en=1 edge:
  - Shift right: shreg <= {s_in, shreg[WIDTH-1:1]}, so the first data bit ends in bit 0.
  - Counter increments by 1.
  - When counter == WIDTH-1 at that edge (i.e. the last data bit is being sampled) -> STOP.
- STOP, on an s_en=1 edge:
  - s_in=1: p_out <= shreg, p_valid=1 for exactly that cycle, then -> IDLE.
  - s_in=0: p_out unchanged, frame_err=1 for exactly that cycle, then -> IDLE.
  - A 0 stop bit is not reused as a new start bit.
- Latency: p_valid asserts on the clock edge that samples the stop bit; p_out is valid in the same cycle as p_valid.
- p_valid and frame_err are registered outputs and are never asserted together.
- busy is 1 in DATA and STOP, 0 in IDLE; it drops on the edge that completes the frame.
- Back-to-back frames: a start bit on the strobe immediately after the stop bit is accepted (no dead strobe required).
- Counter arithmetic: unsigned CNT_W bits; it never wraps, because the state leaves DATA at WIDTH-1.
- s_en held high continuously is legal; the block then receives one bit per clock.

Decomposition:
- Shared header sipo_defs.vh holds:
  - state encodings (ST_IDLE=2'b00, ST_DATA=2'b01, ST_STOP=2'b10);
  - the default WIDTH.
- Unused encoding 2'b11 returns to IDLE on the next edge.
- One sub-module, _bit_cnt: CNT_W-bit counter with synchronous clear (active-high) and enable, plus terminal-count output tc = (count == WIDTH-1).
- The FSM, shift register and output registers live in the top module.

Test Plan (WIDTH=8 unless noted):
- Reset check: reset=1 for 2 clocks with s_in=0, s_en=1 -> p_out=8'h00, p_valid=0, frame_err=0, busy=0 throughout reset and on the first post-reset cycle.
- Single good frame: s_en=1 every clock; s_in sequence 0,1,0,1,1,0,0,1,0,1 (start, data 8'h4D LSB-first, stop) -> busy=1 for 9 cycles, then p_out=8'h4D with p_valid=1 on exactly one cycle.
- Framing error: same frame with stop bit 0 -> frame_err=1 for one cycle, p_valid stays 0, p_out keeps its previous value (8'h4D); the next good frame 8'hA5 is received correctly.
- Strobed input: s_en=1 every 4th clock with s_in changing only on strobes; frame 8'hC3 -> p_out=8'hC3, p_valid=1 for one clock; toggling s_in between strobes has no effect.
- Back-to-back and reset mid-frame: frames 8'hFF then 8'h00 with no idle bit between -> two p_valid pulses, 10 strobes apart. Then start a frame, assert reset after 4 data bits -> busy=0 and p_out=8'h00 next cycle; the following frame 8'h3C is received correctly.
